// File: rtl/vector_seq_pkg.sv
// Shared types and width helpers for the vector sequencer.
package vector_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  // Address width for n vectors; never narrower than one bit.
  function automatic int unsigned addr_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width needed to hold the values 0..n; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n == 0) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/vector_delay_line.sv
// LATENCY-deep valid+data shift register with synchronous flush.
// At LATENCY=0 the input passes straight through.
module vector_delay_line #(
  parameter int unsigned LATENCY = 0,
  parameter int unsigned W       = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_flush,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  if (LATENCY == 0) begin : g_pass
    logic w_unused;
    assign w_unused = &{1'b0, clk, rst_n, i_flush};
    assign o_valid  = i_valid;
    assign o_data   = i_data;
  end else begin : g_pipe
    logic         r_valid [LATENCY];
    logic [W-1:0] r_data  [LATENCY];

    // Shift valid and payload one stage per cycle; flush empties every stage.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned i = 0; i < LATENCY; i++) begin
          r_valid[i] <= 1'b0;
          r_data[i]  <= '0;
        end
      end else if (i_flush) begin
        for (int unsigned i = 0; i < LATENCY; i++) begin
          r_valid[i] <= 1'b0;
          r_data[i]  <= '0;
        end
      end else begin
        r_valid[0] <= i_valid;
        r_data[0]  <= i_data;
        for (int unsigned i = 1; i < LATENCY; i++) begin
          r_valid[i] <= r_valid[i-1];
          r_data[i]  <= r_data[i-1];
        end
      end
    end

    assign o_valid = r_valid[LATENCY-1];
    assign o_data  = r_data[LATENCY-1];
  end

endmodule

// File: rtl/vector_sequencer.sv
// Walks a stimulus/expected ROM, drives a DUT one vector per cycle, compares
// responses after a fixed pipeline latency and reports pass/fail.
module vector_sequencer
  import vector_seq_pkg::*;
#(
  parameter int unsigned NUM_VECTORS = 4,
  parameter int unsigned IN_WIDTH    = 2,
  parameter int unsigned OUT_WIDTH   = 1,
  parameter int unsigned LATENCY     = 0,
  localparam int unsigned AW = addr_width(NUM_VECTORS),
  localparam int unsigned CW = cnt_width(NUM_VECTORS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic [AW-1:0]        rom_addr,
  input  logic [IN_WIDTH-1:0]  rom_stim,
  input  logic [OUT_WIDTH-1:0] rom_exp,
  output logic [IN_WIDTH-1:0]  dut_in,
  input  logic [OUT_WIDTH-1:0] dut_out,
  output logic                 log_valid,
  output logic [OUT_WIDTH-1:0] log_data,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CW-1:0]        err_count,
  output logic [AW-1:0]        first_fail
);

  localparam int unsigned DW         = cnt_width(LATENCY);
  localparam int unsigned DRAIN_INIT = (LATENCY > 0) ? LATENCY - 1 : 0;
  localparam int unsigned PW         = AW + OUT_WIDTH;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_VECTORS - 1);

  seq_state_t          r_state;
  logic [AW-1:0]       r_rom_addr;
  logic                r_busy;
  logic                r_done;
  logic                r_pass;
  logic [CW-1:0]       r_err_count;
  logic [AW-1:0]       r_first_fail;
  logic [DW-1:0]       r_drain;

  logic                w_issue_valid;
  logic [PW-1:0]       w_issue_data;
  logic                w_cmp_valid;
  logic [PW-1:0]       w_cmp_data;
  logic [AW-1:0]       w_cmp_idx;
  logic [OUT_WIDTH-1:0] w_cmp_exp;
  logic                w_mismatch;
  logic                w_pass_next;

  // Each issued vector carries its index and expected response down the pipe.
  assign w_issue_valid = (r_state == RUN);
  assign w_issue_data  = {r_rom_addr, rom_exp};

  vector_delay_line #(
    .LATENCY (LATENCY),
    .W       (PW)
  ) u_delay (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (abort),
    .i_valid (w_issue_valid),
    .i_data  (w_issue_data),
    .o_valid (w_cmp_valid),
    .o_data  (w_cmp_data)
  );

  assign w_cmp_idx   = w_cmp_data[PW-1 -: AW];
  assign w_cmp_exp   = w_cmp_data[OUT_WIDTH-1:0];
  assign w_mismatch  = w_cmp_valid && (dut_out != w_cmp_exp);
  // Pass must account for a compare retiring in the same cycle as the exit.
  assign w_pass_next = (r_err_count == '0) && !w_mismatch;

  // Sequencer FSM plus compare bookkeeping, all registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_rom_addr   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err_count  <= '0;
      r_first_fail <= '0;
      r_drain      <= '0;
    end else begin
      r_done <= 1'b0;

      if (w_mismatch) begin
        r_err_count <= r_err_count + CW'(1);
        if (r_err_count == '0) begin
          r_first_fail <= w_cmp_idx;
        end
      end

      if (abort) begin
        r_state    <= IDLE;
        r_rom_addr <= '0;
        r_busy     <= 1'b0;
        r_pass     <= 1'b0;
        r_drain    <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_state      <= RUN;
              r_busy       <= 1'b1;
              r_rom_addr   <= '0;
              r_err_count  <= '0;
              r_first_fail <= '0;
              r_pass       <= 1'b0;
            end
          end
          RUN: begin
            if (r_rom_addr == LAST_ADDR) begin
              r_rom_addr <= '0;
              if (LATENCY > 0) begin
                r_state <= DRAIN;
                r_drain <= DW'(DRAIN_INIT);
              end else begin
                r_state <= DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_pass  <= w_pass_next;
              end
            end else begin
              r_rom_addr <= r_rom_addr + AW'(1);
            end
          end
          DRAIN: begin
            if (r_drain == '0) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= w_pass_next;
            end else begin
              r_drain <= r_drain - DW'(1);
            end
          end
          DONE: begin
            r_state <= IDLE;
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign rom_addr   = r_rom_addr;
  assign dut_in     = (r_state == RUN) ? rom_stim : '0;
  assign log_valid  = w_cmp_valid;
  assign log_data   = w_cmp_valid ? dut_out : '0;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_count  = r_err_count;
  assign first_fail = r_first_fail;

endmodule

// File: tb/tb_vector_sequencer.sv
// Directed bench for vector_sequencer with a NAND DUT at latency 0 and 2.
module tb_vector_sequencer;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_err;

  logic [1:0] stim_m [4];
  logic       exp_m  [4];

  // Latency-0 instance signals
  logic       start0, abort0;
  logic [1:0] rom_addr0, dut_in0, first_fail0;
  logic       rom_exp0, dut_out0, log_valid0, log_data0, busy0, done0, pass0;
  logic [1:0] rom_stim0;
  logic [2:0] err0;

  // Latency-2 instance signals
  logic       start2, abort2;
  logic [1:0] rom_addr2, dut_in2, first_fail2;
  logic       rom_exp2, dut_out2, log_valid2, log_data2, busy2, done2, pass2;
  logic [1:0] rom_stim2;
  logic [2:0] err2;
  logic       p1, p2;

  typedef struct {
    int   cyc;
    logic data;
  } exp_t;

  exp_t q0[$];
  exp_t q2[$];

  function automatic logic nand2(input logic [1:0] v);
    return ~&v;
  endfunction

  vector_sequencer #(
    .NUM_VECTORS (4),
    .IN_WIDTH    (2),
    .OUT_WIDTH   (1),
    .LATENCY     (0)
  ) u_dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start0),
    .abort      (abort0),
    .rom_addr   (rom_addr0),
    .rom_stim   (rom_stim0),
    .rom_exp    (rom_exp0),
    .dut_in     (dut_in0),
    .dut_out    (dut_out0),
    .log_valid  (log_valid0),
    .log_data   (log_data0),
    .busy       (busy0),
    .done       (done0),
    .pass       (pass0),
    .err_count  (err0),
    .first_fail (first_fail0)
  );

  vector_sequencer #(
    .NUM_VECTORS (4),
    .IN_WIDTH    (2),
    .OUT_WIDTH   (1),
    .LATENCY     (2)
  ) u_dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start2),
    .abort      (abort2),
    .rom_addr   (rom_addr2),
    .rom_stim   (rom_stim2),
    .rom_exp    (rom_exp2),
    .dut_in     (dut_in2),
    .dut_out    (dut_out2),
    .log_valid  (log_valid2),
    .log_data   (log_data2),
    .busy       (busy2),
    .done       (done2),
    .pass       (pass2),
    .err_count  (err2),
    .first_fail (first_fail2)
  );

  // ROMs and DUT models
  assign rom_stim0 = stim_m[rom_addr0];
  assign rom_exp0  = exp_m[rom_addr0];
  assign dut_out0  = nand2(dut_in0);
  assign rom_stim2 = stim_m[rom_addr2];
  assign rom_exp2  = exp_m[rom_addr2];
  assign dut_out2  = p2;

  always @(posedge clk) begin
    p1 <= nand2(dut_in2);
    p2 <= p1;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every logged response must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n && log_valid0) begin
      check("log0_pending", 32'(q0.size() != 0), 32'd1);
      if (q0.size() != 0) begin
        exp_t e0;
        e0 = q0.pop_front();
        check("log0_cycle", cyc, e0.cyc);
        check("log0_data", 32'(log_data0), 32'(e0.data));
      end
    end
    if (rst_n && log_valid2) begin
      check("log2_pending", 32'(q2.size() != 0), 32'd1);
      if (q2.size() != 0) begin
        exp_t e2;
        e2 = q2.pop_front();
        check("log2_cycle", cyc, e2.cyc);
        check("log2_data", 32'(log_data2), 32'(e2.data));
      end
    end
  end

  task automatic model(output int ne, output int ff);
    ne = 0;
    ff = 0;
    for (int k = 0; k < 4; k++) begin
      if (nand2(stim_m[k]) !== exp_m[k]) begin
        if (ne == 0) ff = k;
        ne++;
      end
    end
  endtask

  // Full run on the latency-0 instance; optional start re-pulses in RUN and DONE.
  task automatic run0(input bit repulse);
    int c0, ne, ff;
    model(ne, ff);
    c0 = cyc;
    for (int k = 0; k < 4; k++) q0.push_back('{c0 + 1 + k, nand2(stim_m[k])});
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("run0_dut_in", 32'(dut_in0), 32'(stim_m[k]));
      check("run0_busy", 32'(busy0), 32'd1);
      check("run0_done_early", 32'(done0), 32'd0);
      start0 = repulse && (k == 1);
      step();
      start0 = 1'b0;
    end
    check("run0_done", 32'(done0), 32'd1);
    check("run0_done_cycle", cyc, c0 + 5);
    check("run0_busy_done", 32'(busy0), 32'd0);
    check("run0_pass", 32'(pass0), 32'(ne == 0));
    check("run0_err_count", 32'(err0), ne);
    if (ne != 0) check("run0_first_fail", 32'(first_fail0), ff);
    start0 = repulse;
    step();
    start0 = 1'b0;
    check("run0_done_pulse", 32'(done0), 32'd0);
    check("run0_busy_after", 32'(busy0), 32'd0);
    check("run0_pass_held", 32'(pass0), 32'(ne == 0));
    check("run0_dut_in_idle", 32'(dut_in0), 32'd0);
    step();
    check("run0_no_restart", 32'(busy0), 32'd0);
    check("run0_q_empty", q0.size(), 0);
  endtask

  // Full run on the latency-2 instance.
  task automatic run2();
    int c0, ne, ff;
    model(ne, ff);
    c0 = cyc;
    for (int k = 0; k < 4; k++) q2.push_back('{c0 + 3 + k, nand2(stim_m[k])});
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check("run2_busy", 32'(busy2), 32'd1);
      check("run2_done_early", 32'(done2), 32'd0);
      check("run2_dut_in", 32'(dut_in2), (k < 4) ? 32'(stim_m[k]) : 32'd0);
      step();
    end
    check("run2_done", 32'(done2), 32'd1);
    check("run2_done_cycle", cyc, c0 + 7);
    check("run2_busy_done", 32'(busy2), 32'd0);
    check("run2_pass", 32'(pass2), 32'(ne == 0));
    check("run2_err_count", 32'(err2), ne);
    step();
    check("run2_done_pulse", 32'(done2), 32'd0);
    check("run2_q_empty", q2.size(), 0);
  endtask

  initial begin
    int c0;
    n_checks = 0;
    n_err    = 0;
    cyc      = 0;
    stim_m   = '{2'b00, 2'b01, 2'b10, 2'b11};
    exp_m    = '{1'b1, 1'b1, 1'b1, 1'b0};
    rst_n  = 1'b0;
    start0 = 1'b0;
    abort0 = 1'b0;
    start2 = 1'b0;
    abort2 = 1'b0;
    step();
    step();

    // Reset values
    check("rst_rom_addr", 32'(rom_addr0), 32'd0);
    check("rst_dut_in", 32'(dut_in0), 32'd0);
    check("rst_log_valid", 32'(log_valid0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_pass", 32'(pass0), 32'd0);
    check("rst_err_count", 32'(err0), 32'd0);
    check("rst_first_fail", 32'(first_fail0), 32'd0);
    check("rst2_busy", 32'(busy2), 32'd0);
    check("rst2_log_valid", 32'(log_valid2), 32'd0);
    rst_n = 1'b1;
    step();

    // Clean NAND run, then one corrupted expectation
    run0(1'b0);
    exp_m[2] = 1'b0;
    run0(1'b0);
    exp_m[2] = 1'b1;

    // Pipelined DUT
    run2();

    // Abort in cycle 3 with a mismatch already counted at vector 1
    exp_m[1] = 1'b0;
    c0 = cyc;
    for (int k = 0; k < 3; k++) q0.push_back('{c0 + 1 + k, nand2(stim_m[k])});
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    step();
    step();
    abort0 = 1'b1;
    step();
    abort0 = 1'b0;
    check("abort_cycle", cyc, c0 + 4);
    check("abort_busy", 32'(busy0), 32'd0);
    check("abort_pass", 32'(pass0), 32'd0);
    check("abort_err_count", 32'(err0), 32'd1);
    check("abort_first_fail", 32'(first_fail0), 32'd1);
    check("abort_rom_addr", 32'(rom_addr0), 32'd0);
    check("abort_dut_in", 32'(dut_in0), 32'd0);
    for (int k = 0; k < 4; k++) begin
      check("abort_no_done", 32'(done0), 32'd0);
      step();
    end
    check("abort_q_empty", q0.size(), 0);
    exp_m[1] = 1'b1;

    // Abort and start together in IDLE: abort wins
    start0 = 1'b1;
    abort0 = 1'b1;
    step();
    start0 = 1'b0;
    abort0 = 1'b0;
    check("abort_start_idle", 32'(busy0), 32'd0);
    step();

    // Re-pulsed start ignored, then an identical clean second run
    run0(1'b1);
    run0(1'b0);

    // Asynchronous reset mid-run
    c0 = cyc;
    q0.push_back('{c0 + 1, nand2(stim_m[0])});
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_rom_addr", 32'(rom_addr0), 32'd0);
    check("arst_dut_in", 32'(dut_in0), 32'd0);
    check("arst_log_valid", 32'(log_valid0), 32'd0);
    check("arst_busy", 32'(busy0), 32'd0);
    check("arst_err_count", 32'(err0), 32'd0);
    check("arst_q_empty", q0.size(), 0);
    rst_n = 1'b1;
    step();
    run0(1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
